// File: rtl/wb_pkg.sv
// Shared writeback types and default widths for the register-file write path.
package wb_pkg;

    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [WB_AW-1:0] regn;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writer_if.sv
// Writeback request/drain bundle: ALU and load requests in, register-file write port and scoreboard out.
interface regfile_writer_if #(
    parameter int AW = wb_pkg::WB_AW,
    parameter int DW = wb_pkg::WB_DW
);
    logic                 alu_valid;
    logic                 alu_ready;
    logic [AW-1:0]        alu_reg;
    logic [DW-1:0]        alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [AW-1:0]        mem_reg;
    logic [DW-1:0]        mem_data;
    logic                 hold;
    logic                 wr;
    logic [AW-1:0]        wreg;
    logic [DW-1:0]        wdata;
    logic [(1<<AW)-1:0]   busy_mask;
    logic                 empty;
    logic                 full;

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, hold,
        input  alu_ready, mem_ready, wr, wreg, wdata, busy_mask, empty, full
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, hold,
        output alu_ready, mem_ready, wr, wreg, wdata, busy_mask, empty, full
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO with wrap-bit pointers; exposes head, all slots and an occupancy vector.
// Push is ignored when full and pop when empty; state changes one edge after the request.
module wb_fifo
    import wb_pkg::*;
#(
    parameter type T     = wb_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  T                    i_dat,
    input  logic                i_pop,
    output logic                o_empty,
    output logic                o_full,
    output T                    o_head,
    output T [DEPTH-1:0]        o_slots,
    output logic [DEPTH-1:0]    o_occ
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    T [DEPTH-1:0]   r_mem;
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [PW-1:0]  w_count;
    logic [PW-1:0]  w_off;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[IW-1:0] == r_rptr[IW-1:0]) && (r_wptr[IW] != r_rptr[IW]);
    assign o_head  = r_mem[r_rptr[IW-1:0]];
    assign o_slots = r_mem;
    assign w_count = r_wptr - r_rptr;

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        o_occ = '0;
        w_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off    = (PW'(i) - r_rptr) & PW'(DEPTH - 1);
            o_occ[i] = (w_off < w_count);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_mem[r_wptr[IW-1:0]] <= i_dat;
                r_wptr                <= r_wptr + PW'(1);
            end
            if (i_pop && !o_empty) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// Arbitrates ALU/load writebacks (load wins) into an in-order queue drained one write per cycle.
// One cycle from acceptance to wr; readies drop only on full, and a full queue refuses even while popping.
module regfile_writer
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_writer_if.slave     bus
);
    typedef struct packed {
        logic [AW-1:0] regn;
        logic [DW-1:0] data;
    } entry_t;

    logic               w_empty;
    logic               w_full;
    logic               w_alu_rdy;
    logic               w_mem_xfer;
    logic               w_alu_xfer;
    logic               w_push;
    logic               w_pop;
    entry_t             w_sel;
    entry_t             w_head;
    entry_t [DEPTH-1:0] w_slots;
    logic [DEPTH-1:0]   w_occ;
    logic [(1<<AW)-1:0] w_busy;

    // Readies depend only on queue state and mem_valid, never on request data.
    assign w_alu_rdy     = !w_full && !bus.mem_valid;
    assign bus.mem_ready = !w_full;
    assign bus.alu_ready = w_alu_rdy;

    assign w_mem_xfer = bus.mem_valid && !w_full;
    assign w_alu_xfer = bus.alu_valid && w_alu_rdy;
    assign w_sel      = w_mem_xfer ? {bus.mem_reg, bus.mem_data} : {bus.alu_reg, bus.alu_data};

    // r0 requests complete the handshake but are dropped here.
    assign w_push = (w_mem_xfer || w_alu_xfer) && (w_sel.regn != AW'(REG_ZERO));

    assign bus.wr    = !w_empty && !bus.hold;
    assign w_pop     = bus.wr;
    assign bus.wreg  = w_empty ? '0 : w_head.regn;
    assign bus.wdata = w_empty ? '0 : w_head.data;
    assign bus.empty = w_empty;
    assign bus.full  = w_full;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_occ[i]) begin
                w_busy[w_slots[i].regn] = 1'b1;
            end
        end
    end

    assign bus.busy_mask = w_busy;

    wb_fifo #(
        .T      (entry_t),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_dat   (w_sel),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_head  (w_head),
        .o_slots (w_slots),
        .o_occ   (w_occ)
    );

endmodule

// File: tb/tb_regfile_writer.sv
// Directed per-cycle vectors plus a mid-operation reset sequence for regfile_writer.
module tb_regfile_writer;

    logic clk;
    logic rst_n;

    regfile_writer_if #(.AW(5), .DW(32)) bus ();

    regfile_writer #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        hold;
        logic        e_ar;
        logic        e_mr;
        logic        e_wr;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic [31:0] e_mask;
        logic        e_empty;
        logic        e_full;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    int n_pass  = 0;
    int n_total = 0;

    function automatic vec_t mk(
        input logic av, input logic [4:0] ar, input logic [31:0] ad,
        input logic mv, input logic [4:0] mr, input logic [31:0] md, input logic hold,
        input logic e_ar, input logic e_mr, input logic e_wr, input logic [4:0] e_wreg,
        input logic [31:0] e_wdata, input logic [31:0] e_mask, input logic e_empty, input logic e_full);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md; v.hold = hold;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_wr = e_wr; v.e_wreg = e_wreg; v.e_wdata = e_wdata;
        v.e_mask = e_mask; v.e_empty = e_empty; v.e_full = e_full;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    endtask

    task automatic chk_outs(input int row, input logic e_ar, input logic e_mr, input logic e_wr,
                            input logic [4:0] e_wreg, input logic [31:0] e_wdata,
                            input logic [31:0] e_mask, input logic e_empty, input logic e_full);
        chk("alu_ready", row, 32'(bus.alu_ready), 32'(e_ar));
        chk("mem_ready", row, 32'(bus.mem_ready), 32'(e_mr));
        chk("wr",        row, 32'(bus.wr),        32'(e_wr));
        chk("wreg",      row, 32'(bus.wreg),      32'(e_wreg));
        chk("wdata",     row, bus.wdata,          e_wdata);
        chk("busy_mask", row, bus.busy_mask,      e_mask);
        chk("empty",     row, 32'(bus.empty),     32'(e_empty));
        chk("full",      row, 32'(bus.full),      32'(e_full));
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md, input logic hold);
        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
        bus.hold      = hold;
    endtask

    initial begin
        // Single ALU write
        vecs[0]  = mk(0,0,0,          0,0,0,    0, 1,1,0,0,0,           32'h0,     1,0);
        vecs[1]  = mk(1,3,32'hDEADBEEF,0,0,0,   0, 1,1,0,0,0,           32'h0,     1,0);
        vecs[2]  = mk(0,0,0,          0,0,0,    0, 1,1,1,3,32'hDEADBEEF,32'h8,     0,0);
        vecs[3]  = mk(0,0,0,          0,0,0,    0, 1,1,0,0,0,           32'h0,     1,0);
        // Simultaneous requests: mem first, then ALU, back-to-back writes
        vecs[4]  = mk(1,6,32'h22,     1,5,32'h11,0, 0,1,0,0,0,          32'h0,     1,0);
        vecs[5]  = mk(1,6,32'h22,     0,0,0,    0, 1,1,1,5,32'h11,      32'h20,    0,0);
        vecs[6]  = mk(0,0,0,          0,0,0,    0, 1,1,1,6,32'h22,      32'h40,    0,0);
        vecs[7]  = mk(0,0,0,          0,0,0,    0, 1,1,0,0,0,           32'h0,     1,0);
        // Fill under hold, refuse push on full even while popping, then drain
        vecs[8]  = mk(1,1,32'hA1,     0,0,0,    1, 1,1,0,0,0,           32'h0,     1,0);
        vecs[9]  = mk(1,2,32'hA2,     0,0,0,    1, 1,1,0,1,32'hA1,      32'h2,     0,0);
        vecs[10] = mk(0,0,0,          1,3,32'hA3,1, 0,1,0,1,32'hA1,     32'h6,     0,0);
        vecs[11] = mk(1,4,32'hA4,     0,0,0,    1, 1,1,0,1,32'hA1,      32'hE,     0,0);
        vecs[12] = mk(1,8,32'hBB,     0,0,0,    1, 0,0,0,1,32'hA1,      32'h1E,    0,1);
        vecs[13] = mk(1,8,32'hBB,     0,0,0,    0, 0,0,1,1,32'hA1,      32'h1E,    0,1);
        vecs[14] = mk(0,0,0,          0,0,0,    0, 1,1,1,2,32'hA2,      32'h1C,    0,0);
        vecs[15] = mk(0,0,0,          0,0,0,    0, 1,1,1,3,32'hA3,      32'h18,    0,0);
        vecs[16] = mk(0,0,0,          0,0,0,    0, 1,1,1,4,32'hA4,      32'h10,    0,0);
        vecs[17] = mk(0,0,0,          0,0,0,    0, 1,1,0,0,0,           32'h0,     1,0);
        // r0 filtering
        vecs[18] = mk(1,0,32'hFFFF,   0,0,0,    0, 1,1,0,0,0,           32'h0,     1,0);
        vecs[19] = mk(0,0,0,          0,0,0,    0, 1,1,0,0,0,           32'h0,     1,0);
        // Same-register ordering
        vecs[20] = mk(1,7,32'h1,      0,0,0,    0, 1,1,0,0,0,           32'h0,     1,0);
        vecs[21] = mk(1,7,32'h2,      0,0,0,    0, 1,1,1,7,32'h1,       32'h80,    0,0);
        vecs[22] = mk(0,0,0,          0,0,0,    0, 1,1,1,7,32'h2,       32'h80,    0,0);
        vecs[23] = mk(0,0,0,          0,0,0,    0, 1,1,0,0,0,           32'h0,     1,0);

        rst_n = 1'b0;
        drive(0,0,0,0,0,0,0);

        // State while held in reset, including alu_ready gated by mem_valid
        repeat (2) @(negedge clk);
        #1 chk_outs(100, 1,1,0,0,0,32'h0,1,0);
        bus.mem_valid = 1'b1;
        #1 chk("rst_alu_ready_memv", 101, 32'(bus.alu_ready), 32'd0);
        chk("rst_mem_ready_memv", 101, 32'(bus.mem_ready), 32'd1);
        bus.mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md, vecs[i].hold);
            #1 chk_outs(i, vecs[i].e_ar, vecs[i].e_mr, vecs[i].e_wr, vecs[i].e_wreg,
                        vecs[i].e_wdata, vecs[i].e_mask, vecs[i].e_empty, vecs[i].e_full);
        end

        // Reset mid-operation: three held entries are discarded asynchronously
        @(negedge clk); drive(1,9, 32'h99,0,0,0,1);
        @(negedge clk); drive(1,10,32'h10,0,0,0,1);
        @(negedge clk); drive(1,11,32'h11,0,0,0,1);
        @(negedge clk); drive(0,0,0,0,0,0,1);
        #1 chk("pre_rst_mask", 200, bus.busy_mask, 32'h0E00);
        chk("pre_rst_wreg", 200, 32'(bus.wreg), 32'd9);
        #2 rst_n = 1'b0;
        #1 chk_outs(201, 1,1,0,0,0,32'h0,1,0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("post_rst_wr", 202 + k, 32'(bus.wr), 32'd0);
            chk("post_rst_empty", 202 + k, 32'(bus.empty), 32'd1);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
